// File: rtl/fib_hls_deadlock_pkg.sv
// Shared types and default widths for the fib HLS deadlock reporter slice.
package fib_hls_deadlock_pkg;

  localparam int unsigned NUM_MON_DEF  = 4;
  localparam int unsigned THRESH_W_DEF = 16;
  localparam int unsigned TS_W_DEF     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WATCH  = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Report payload as seen by the host at the default widths.
  typedef struct packed {
    logic [NUM_MON_DEF-1:0] mask;
    logic [TS_W_DEF-1:0]    cycles;
  } report_t;

endpackage

// File: rtl/fib_hls_stall_counter.sv
// One saturating persistence counter for a single monitor block flag,
// compared against the live threshold (zero behaves as one).
module fib_hls_stall_counter
  import fib_hls_deadlock_pkg::*;
#(
  parameter int unsigned THRESH_W = THRESH_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                blk,
  input  logic [THRESH_W-1:0] thr,
  output logic                stalled
);

  logic [THRESH_W-1:0] cnt_q;
  logic [THRESH_W-1:0] cnt_d;
  logic [THRESH_W-1:0] thr_eff;

  always_comb begin
    cnt_d = '0;
    if (en && blk) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_comb begin
    thr_eff = thr;
    if (thr == '0) begin
      thr_eff = {{(THRESH_W-1){1'b0}}, 1'b1};
    end
  end

  assign stalled = (cnt_q >= thr_eff);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fib_hls_deadlock_reporter.sv
// Confirms persistent monitor stalls, emits one report beat per episode and
// holds a sticky deadlock flag until the host clears it.
module fib_hls_deadlock_reporter
  import fib_hls_deadlock_pkg::*;
#(
  parameter int unsigned NUM_MON  = NUM_MON_DEF,
  parameter int unsigned THRESH_W = THRESH_W_DEF,
  parameter int unsigned TS_W     = TS_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_MON-1:0]  mon_block,
  input  logic                cfg_enable,
  input  logic [THRESH_W-1:0] cfg_threshold,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [NUM_MON-1:0]  report_mask,
  output logic [TS_W-1:0]     report_cycles,
  output logic                deadlock,
  input  logic                clear_req
);

  state_e             state_q, state_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic               valid_q, valid_d;
  logic [NUM_MON-1:0] mask_q, mask_d;
  logic [TS_W-1:0]    cycles_q, cycles_d;
  logic               deadlock_q, deadlock_d;
  logic [NUM_MON-1:0] stalled;
  logic               watch_en;

  // Counters only run while watching; every other state holds them at zero.
  assign watch_en = cfg_enable && (state_q == WATCH);

  for (genvar i = 0; i < NUM_MON; i++) begin : gen_cnt
    fib_hls_stall_counter #(
      .THRESH_W (THRESH_W)
    ) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .en      (watch_en),
      .blk     (mon_block[i]),
      .thr     (cfg_threshold),
      .stalled (stalled[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q + 1'b1;
    valid_d    = valid_q;
    mask_d     = mask_q;
    cycles_d   = cycles_q;
    deadlock_d = deadlock_q;
    case (state_q)
      IDLE: begin
        if (cfg_enable) state_d = WATCH;
      end
      WATCH: begin
        if (!cfg_enable) begin
          state_d = IDLE;
        end else if (|stalled) begin
          state_d    = REPORT;
          mask_d     = stalled;
          cycles_d   = ts_q;
          valid_d    = 1'b1;
          deadlock_d = 1'b1;
        end
      end
      REPORT: begin
        if (report_ready) begin
          state_d = HOLD;
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (clear_req) begin
          deadlock_d = 1'b0;
          mask_d     = '0;
          state_d    = cfg_enable ? WATCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      valid_q    <= 1'b0;
      mask_q     <= '0;
      cycles_q   <= '0;
      deadlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      valid_q    <= valid_d;
      mask_q     <= mask_d;
      cycles_q   <= cycles_d;
      deadlock_q <= deadlock_d;
    end
  end

  assign report_valid  = valid_q;
  assign report_mask   = mask_q;
  assign report_cycles = cycles_q;
  assign deadlock      = deadlock_q;

endmodule

// File: tb/tb_fib_hls_deadlock_reporter.sv
// Directed bench for the deadlock reporter; a second instance with a narrow
// timestamp exercises wrap with the maximum threshold.
module tb_fib_hls_deadlock_reporter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  mon_block;
  logic        cfg_enable;
  logic [15:0] cfg_threshold;
  logic        report_ready;
  logic        clear_req;
  logic        rv;
  logic [3:0]  rm;
  logic [31:0] rc;
  logic        dl;

  logic [3:0]  mon_b;
  logic        en_b;
  logic [15:0] thr_b;
  logic        ready_b;
  logic        clr_b;
  logic        rv_b;
  logic [3:0]  rm_b;
  logic [7:0]  rc_b;
  logic        dl_b;

  int checks = 0;
  int failures = 0;
  int unsigned e_ts;
  logic [7:0] exp8;

  always #5 clock = ~clock;

  fib_hls_deadlock_reporter u_dut (
    .clock (clock), .reset (reset), .mon_block (mon_block),
    .cfg_enable (cfg_enable), .cfg_threshold (cfg_threshold),
    .report_valid (rv), .report_ready (report_ready), .report_mask (rm),
    .report_cycles (rc), .deadlock (dl), .clear_req (clear_req)
  );

  fib_hls_deadlock_reporter #(
    .NUM_MON (4), .THRESH_W (16), .TS_W (8)
  ) u_dut_w (
    .clock (clock), .reset (reset), .mon_block (mon_b),
    .cfg_enable (en_b), .cfg_threshold (thr_b),
    .report_valid (rv_b), .report_ready (ready_b), .report_mask (rm_b),
    .report_cycles (rc_b), .deadlock (dl_b), .clear_req (clr_b)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Edge k after reset release sees the DUT timestamp equal to k; cyc tracks k.
  int unsigned cyc;
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic do_reset();
    reset = 1'b1;
    mon_block = '0; cfg_enable = 1'b0; cfg_threshold = '0;
    report_ready = 1'b0; clear_req = 1'b0;
    mon_b = '0; en_b = 1'b0; thr_b = '0; ready_b = 1'b0; clr_b = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rv !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rv); end
    checks++; if (rm !== 4'b0) begin failures++; $display("FAIL reset_mask got=%b exp=0000", rm); end
    checks++; if (rc !== 32'd0) begin failures++; $display("FAIL reset_cycles got=%0d exp=0", rc); end
    checks++; if (dl !== 1'b0) begin failures++; $display("FAIL reset_deadlock got=%b exp=0", dl); end
  endtask

  task automatic test_latency();
    do_reset();
    cfg_enable = 1'b1; cfg_threshold = 16'd3; report_ready = 1'b1;
    for (int i = 0; i < 20 && cyc < 10; i++) tick(1);
    mon_block = 4'b0100;
    tick(3);
    checks++; if (rv !== 1'b0) begin failures++; $display("FAIL lat_early got=%b exp=0", rv); end
    tick(1);
    checks++; if (rv !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b exp=1", rv); end
    checks++; if (rm !== 4'b0100) begin failures++; $display("FAIL lat_mask got=%b exp=0100", rm); end
    checks++; if (rc !== 32'd13) begin failures++; $display("FAIL lat_cycles got=%0d exp=13", rc); end
    checks++; if (dl !== 1'b1) begin failures++; $display("FAIL lat_deadlock got=%b exp=1", dl); end
    tick(1);
    checks++; if (rv !== 1'b0 || dl !== 1'b1) begin failures++; $display("FAIL lat_handshake got=v%b d%b exp=v0 d1", rv, dl); end
  endtask

  task automatic test_glitch();
    do_reset();
    cfg_enable = 1'b1; cfg_threshold = 16'd3; report_ready = 1'b1;
    tick(2);
    mon_block = 4'b0010; tick(2);
    mon_block = 4'b0000; tick(1);
    mon_block = 4'b0010; tick(2);
    mon_block = 4'b0000; tick(3);
    checks++; if (rv !== 1'b0 || dl !== 1'b0) begin failures++; $display("FAIL glitch_noreport got=v%b d%b exp=v0 d0", rv, dl); end
    mon_block = 4'b0010; tick(2);
    mon_block = 4'b0000; tick(2);
    checks++; if (rv !== 1'b0 || dl !== 1'b0) begin failures++; $display("FAIL glitch_restart got=v%b d%b exp=v0 d0", rv, dl); end
    mon_block = 4'b0010; tick(4);
    checks++; if (rv !== 1'b1 || rm !== 4'b0010) begin failures++; $display("FAIL glitch_full got=v%b m%b exp=v1 m0010", rv, rm); end
    mon_block = 4'b0000; tick(1);
  endtask

  task automatic test_back_to_back_mask();
    do_reset();
    cfg_enable = 1'b1; cfg_threshold = 16'd2; report_ready = 1'b0;
    tick(2);
    mon_block = 4'b1001; e_ts = cyc;
    tick(2);
    checks++; if (rv !== 1'b0) begin failures++; $display("FAIL multi_early got=%b exp=0", rv); end
    tick(1);
    checks++; if (rv !== 1'b1 || rm !== 4'b1001) begin failures++; $display("FAIL multi_valid got=v%b m%b exp=v1 m1001", rv, rm); end
    mon_block = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (rv !== 1'b1 || rm !== 4'b1001 || rc !== e_ts + 2) begin
        failures++;
        $display("FAIL multi_stall%0d got=v%b m%b c%0d exp=v1 m1001 c%0d", i, rv, rm, rc, e_ts + 2);
      end
    end
    report_ready = 1'b1;
    tick(1);
    checks++; if (rv !== 1'b0 || dl !== 1'b1) begin failures++; $display("FAIL multi_accept got=v%b d%b exp=v0 d1", rv, dl); end
  endtask

  task automatic test_clear_rearm();
    mon_block = 4'b0100; cfg_threshold = 16'd3;
    tick(3);
    checks++; if (rv !== 1'b0 || dl !== 1'b1) begin failures++; $display("FAIL hold_sticky got=v%b d%b exp=v0 d1", rv, dl); end
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    checks++; if (dl !== 1'b0 || rm !== 4'b0) begin failures++; $display("FAIL clear got=d%b m%b exp=d0 m0000", dl, rm); end
    tick(3);
    checks++; if (rv !== 1'b0) begin failures++; $display("FAIL rearm_early got=%b exp=0", rv); end
    tick(1);
    checks++; if (rv !== 1'b1 || rm !== 4'b0100 || dl !== 1'b1) begin failures++; $display("FAIL rearm_report got=v%b m%b d%b exp=v1 m0100 d1", rv, rm, dl); end
    tick(1);
    mon_block = 4'b0000;
  endtask

  task automatic test_thr_zero();
    do_reset();
    cfg_enable = 1'b1; cfg_threshold = 16'd0; report_ready = 1'b1;
    tick(2);
    mon_block = 4'b0010; e_ts = cyc;
    tick(1);
    checks++; if (rv !== 1'b0) begin failures++; $display("FAIL thr0_early got=%b exp=0", rv); end
    tick(1);
    checks++; if (rv !== 1'b1 || rc !== e_ts + 1) begin failures++; $display("FAIL thr0_report got=v%b c%0d exp=v1 c%0d", rv, rc, e_ts + 1); end
    mon_block = 4'b0000;
  endtask

  task automatic test_wrap_saturate();
    int early;
    do_reset();
    en_b = 1'b1; thr_b = 16'hFFFF; ready_b = 1'b1;
    tick(2);
    mon_b = 4'b0001; e_ts = cyc;
    early = 0;
    for (int i = 0; i < 65535; i++) begin
      tick(1);
      if (rv_b !== 1'b0) early++;
    end
    checks++; if (early != 0) begin failures++; $display("FAIL wrap_early got=%0d exp=0", early); end
    tick(1);
    exp8 = 8'(e_ts + 65535);
    checks++; if (rv_b !== 1'b1 || rm_b !== 4'b0001) begin failures++; $display("FAIL wrap_valid got=v%b m%b exp=v1 m0001", rv_b, rm_b); end
    checks++; if (rc_b !== exp8) begin failures++; $display("FAIL wrap_cycles got=%0d exp=%0d", rc_b, exp8); end
    mon_b = 4'b0000; en_b = 1'b0;
  endtask

  task automatic test_reset_mid_report();
    do_reset();
    cfg_enable = 1'b1; cfg_threshold = 16'd1; report_ready = 1'b0;
    tick(2);
    mon_block = 4'b1000;
    tick(2);
    checks++; if (rv !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b exp=1", rv); end
    reset = 1'b1;
    tick(1);
    checks++;
    if (rv !== 1'b0 || rm !== 4'b0 || rc !== 32'd0 || dl !== 1'b0) begin
      failures++;
      $display("FAIL midrst_clear got=v%b m%b c%0d d%b exp=all 0", rv, rm, rc, dl);
    end
    reset = 1'b0;
    mon_block = 4'b0000;
  endtask

  task automatic test_disable_clears();
    cfg_enable = 1'b1; cfg_threshold = 16'd3; report_ready = 1'b1; mon_block = 4'b0000;
    tick(2);
    mon_block = 4'b0001;
    tick(2);
    cfg_enable = 1'b0;
    tick(1);
    checks++; if (rv !== 1'b0 || dl !== 1'b0) begin failures++; $display("FAIL dis_noreport got=v%b d%b exp=v0 d0", rv, dl); end
    cfg_enable = 1'b1;
    tick(1);
    tick(3);
    checks++; if (rv !== 1'b0) begin failures++; $display("FAIL dis_restart got=%b exp=0", rv); end
    tick(1);
    checks++; if (rv !== 1'b1 || rm !== 4'b0001) begin failures++; $display("FAIL dis_report got=v%b m%b exp=v1 m0001", rv, rm); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_back_to_back_mask();
    test_clear_rearm();
    test_thr_zero();
    test_wrap_saturate();
    test_reset_mid_report();
    test_disable_clears();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
